// File: rtl/unsigned_64by32_seq_div.sv
// unsigned_64by32_seq_div
//   Multi-cycle exact unsigned divider: a 2*DW-bit dividend divided by a DW-bit
//   divisor gives a DW-bit quotient and remainder. It uses radix-2 restoring
//   division and produces one quotient bit per clock. Only one operation is in
//   flight at a time.
//
//   Divide-by-zero and quotient overflow are detected up front, in one cycle.
//   In either case the datapath is skipped and a saturated quotient is returned.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands accepted (IDLE only)
//   dividend   in   2*DW   unsigned dividend
//   divisor    in   DW     unsigned divisor
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      result consumed
//   quotient   out  DW     unsigned quotient
//   remainder  out  DW     unsigned remainder
//   div_zero   out  1      divisor was zero
//   overflow   out  1      true quotient does not fit in DW bits
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// CHECK | one cycle: classify zero divisor / overflow / normal
// RUN   | DW cycles, one restoring step per cycle
// DONE  | result held, out_valid high until out_ready
module unsigned_64by32_seq_div #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   quotient,
   output logic [DW-1:0]   remainder,
   output logic            div_zero,
   output logic            overflow
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_RUN,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   hi_q, hi_d;     // upper dividend half, seeds the remainder
   logic [DW-1:0]   shf_q, shf_d;   // lower dividend half, shifted out MSB first
   logic [DW-1:0]   dsr_q, dsr_d;
   logic [DW-1:0]   rem_q, rem_d;
   logic [DW-1:0]   quo_q, quo_d;
   logic [CW-1:0]   cnt_q, cnt_d;   // steps left in RUN, terminal at zero
   logic            dz_q, dz_d;
   logic            ov_q, ov_d;

   logic [DW:0]     trial;
   logic [DW-1:0]   diff;
   logic            ge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         shf_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         shf_q   <= shf_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      shf_d   = shf_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      ov_d    = ov_q;

      // rem_q < dsr_q holds throughout RUN, so trial < 2*divisor and the
      // difference fits in DW bits whenever trial >= divisor.
      trial = {rem_q, shf_q[DW-1]};
      ge    = (trial >= {1'b0, dsr_q});
      diff  = trial[DW-1:0] - dsr_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               hi_d    = dividend[2*DW-1:DW];
               shf_d   = dividend[DW-1:0];
               dsr_d   = divisor;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (dsr_q == '0) begin
               dz_d    = 1'b1;
               ov_d    = 1'b0;
               quo_d   = '1;
               rem_d   = shf_q;
               state_d = S_DONE;
            end else if (hi_q >= dsr_q) begin
               dz_d    = 1'b0;
               ov_d    = 1'b1;
               quo_d   = '1;
               rem_d   = '0;
               state_d = S_DONE;
            end else begin
               dz_d    = 1'b0;
               ov_d    = 1'b0;
               quo_d   = '0;
               rem_d   = hi_q;
               cnt_d   = CW'(DW - 1);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            rem_d = ge ? diff : trial[DW-1:0];
            quo_d = {quo_q[DW-2:0], ge};
            shf_d = {shf_q[DW-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;
   assign overflow  = ov_q;

endmodule

// File: tb/tb_unsigned_64by32_seq_div.sv
module tb_unsigned_64by32_seq_div;

   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [2*DW-1:0] dividend;
   logic [DW-1:0]   divisor;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   quotient;
   logic [DW-1:0]   remainder;
   logic            div_zero;
   logic            overflow;

   always #5 clk = ~clk;

   unsigned_64by32_seq_div #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   typedef struct {
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      logic          dz;
      logic          ov;
      longint        acc_t;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   total   = 0;
   int   bad     = 0;
   int   issued  = 0;
   int   hs_cnt  = 0;
   int   stall_n = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [DW-1:0] q, input logic [DW-1:0] r,
                               input logic dz, input logic ov);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz; e.ov = ov;
      e.acc_t = 0;
      e.lat = (dz || ov) ? 2 : 2 + DW;
      return e;
   endfunction

   function automatic exp_t model(input logic [2*DW-1:0] z, input logic [DW-1:0] y);
      logic [2*DW-1:0] q64, r64;
      if (y == '0) return mk('1, z[DW-1:0], 1'b1, 1'b0);
      if (z[2*DW-1:DW] >= y) return mk('1, '0, 1'b0, 1'b1);
      q64 = z / {32'd0, y};
      r64 = z % {32'd0, y};
      return mk(q64[DW-1:0], r64[DW-1:0], 1'b0, 1'b0);
   endfunction

   task automatic issue(input logic [2*DW-1:0] z, input logic [DW-1:0] y,
                        input exp_t e, input bit push);
      int   n;
      logic rdy;
      exp_t ee;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      dividend = z;
      divisor  = y;
      forever begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) break;
         n++;
         if (n > 2000) begin
            $display("FAIL accept_timeout actual=stuck required=in_ready");
            $display("test done: total=%0d bad=%0d", total, bad + 1);
            $fatal(1);
         end
      end
      chk("accept_after_handshake", 64'(hs_cnt), 64'(issued));
      if (push) begin
         ee = e;
         ee.acc_t = $time;
         sb.push_back(ee);
         issued++;
      end
      #1;
      in_valid = 1'b0;
      dividend = ~z;
      divisor  = ~y;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
      chk({tag, "_quotient"},  64'(quotient),  64'd0);
      chk({tag, "_remainder"}, 64'(remainder), 64'd0);
      chk({tag, "_div_zero"},  64'(div_zero),  64'd0);
      chk({tag, "_overflow"},  64'(overflow),  64'd0);
   endtask

   // out_ready: held low for stall_n cycles of out_valid, otherwise high.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_n > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_n--;
         end else begin
            out_ready = (stall_n == 0);
         end
      end
   end

   // Monitor / scoreboard
   bit   m_busy = 0;
   bit   m_have = 0;
   exp_t m_cur;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_busy = 0;
         end else if (out_valid) begin
            if (!m_busy) begin
               m_busy = 1;
               if (sb.size() == 0) begin
                  m_have = 0;
                  total++;
                  bad++;
                  $display("FAIL unexpected_result actual=out_valid required=no_result at %0t", $time);
               end else begin
                  m_have = 1;
                  m_cur = sb.pop_front();
                  chk("quotient",  64'(quotient),  64'(m_cur.q));
                  chk("remainder", 64'(remainder), 64'(m_cur.r));
                  chk("div_zero",  64'(div_zero),  64'(m_cur.dz));
                  chk("overflow",  64'(overflow),  64'(m_cur.ov));
                  chk("latency", 64'($time + 5), 64'(m_cur.acc_t + 64'(m_cur.lat) * 10));
               end
            end else if (m_have) begin
               chk("hold_quotient",  64'(quotient),  64'(m_cur.q));
               chk("hold_remainder", 64'(remainder), 64'(m_cur.r));
               chk("hold_flags", 64'({div_zero, overflow}), 64'({m_cur.dz, m_cur.ov}));
            end
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_ready) begin
               hs_cnt++;
               m_busy = 0;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      logic [2*DW-1:0] z;
      logic [DW-1:0]   x, y;
      int              n;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_vals("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // directed vectors, hand-computed
      issue(64'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0), 1);
      issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0), 1);
      issue(64'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0), 1);
      issue(64'h0000_0001_0000_0000, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1), 1);
      issue(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0), 1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1), 1);
      issue(64'hABCD_0000_1234_5678, 32'd0, mk(32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0), 1);
      issue(64'd0, 32'd5, mk(32'd0, 32'd0, 1'b0, 1'b0), 1);
      issue(64'h0000_0000_FFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0), 1);
      issue(64'd6, 32'd7, mk(32'd0, 32'd6, 1'b0, 1'b0), 1);

      // back-pressure: result held 5 cycles, queued operands wait for handshake
      stall_n = 5;
      issue(64'd1000, 32'd10, mk(32'd100, 32'd0, 1'b0, 1'b0), 1);
      z = 64'h1234_5678_9ABC_DEF0;
      issue(z, 32'h8765_4321, model(z, 32'h8765_4321), 1);

      // reset during the 10th RUN cycle
      n = 0;
      while (hs_cnt != issued && n < 200) begin @(posedge clk); n++; end
      issue(64'd100, 32'd7, mk('0, '0, 1'b0, 1'b0), 0);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      chk_reset_vals("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(64'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0), 1);

      // mixed vectors against the reference model
      for (int i = 0; i < 200; i++) begin
         x = $urandom;
         y = $urandom;
         unique case (i % 4)
            0: z = {$urandom, $urandom};
            1: begin y = 32'd1; z = {32'd0, x}; end
            2: begin if (y == '0) y = 32'd3; z = 64'(x) * 64'(y); end
            default: begin
               if (y == '0) y = 32'd9;
               z = {x % y, 32'($urandom)};
            end
         endcase
         stall_n = int'($urandom_range(0, 2));
         issue(z, y, model(z, y), 1);
      end

      n = 0;
      while (hs_cnt != issued && n < 5000) begin @(posedge clk); n++; end
      chk("drain_handshakes", 64'(hs_cnt), 64'(issued));
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
